// File: rtl/spgemm_csr_engine_if.sv
// spgemm_csr_engine_if: operand/result bundle for the CSR SpGEMM engine.
// master drives operands and start, slave returns the CSR result.
interface spgemm_csr_engine_if #(
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 4,
  parameter int MAX_NNZ  = 16,
  parameter int MAX_ROWS = 15
);
  logic                            start_i;
  logic [IDX_W-1:0]                rows_a_i;
  logic [IDX_W-1:0]                rows_b_i;
  logic [MAX_NNZ*DATA_W-1:0]       nva_i;
  logic [MAX_NNZ*DATA_W-1:0]       nvb_i;
  logic [MAX_NNZ*IDX_W-1:0]        cia_i;
  logic [MAX_NNZ*IDX_W-1:0]        cib_i;
  logic [(MAX_ROWS+1)*IDX_W-1:0]   rpa_i;
  logic [(MAX_ROWS+1)*IDX_W-1:0]   rpb_i;
  logic [MAX_NNZ*DATA_W-1:0]       nvc_o;
  logic [MAX_NNZ*IDX_W-1:0]        cic_o;
  logic [(MAX_ROWS+1)*IDX_W-1:0]   rpc_o;
  logic [IDX_W:0]                  nnz_c_o;
  logic                            busy_o;
  logic                            done_o;
  logic                            ovf_o;
  logic                            idx_err_o;

  modport master (
    output start_i, rows_a_i, rows_b_i,
    output nva_i, nvb_i, cia_i, cib_i, rpa_i, rpb_i,
    input  nvc_o, cic_o, rpc_o, nnz_c_o,
    input  busy_o, done_o, ovf_o, idx_err_o
  );

  modport slave (
    input  start_i, rows_a_i, rows_b_i,
    input  nva_i, nvb_i, cia_i, cib_i, rpa_i, rpb_i,
    output nvc_o, cic_o, rpc_o, nnz_c_o,
    output busy_o, done_o, ovf_o, idx_err_o
  );
endinterface

// File: rtl/spgemm_csr_engine.sv
// spgemm_csr_engine: C = A*B over CSR, row-wise Gustavson sorted merge.
// Define SPGEMM_SAT_EN for saturating multiply/accumulate (default wraps).
module spgemm_csr_engine #(
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 4,
  parameter int MAX_NNZ  = 16,
  parameter int MAX_ROWS = 15
) (
  input logic clk_i,
  input logic rst_ni,
  spgemm_csr_engine_if.slave bus
);
  localparam int PW = IDX_W + 1;
  localparam int AW = (MAX_NNZ > 1) ? $clog2(MAX_NNZ) : 1;
  localparam int RW = $clog2(MAX_ROWS + 1);

`ifdef SPGEMM_SAT_EN
  localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    IDLE, ROW_A, ELEM_A, MERGE, ROW_END, DONE
  } state_e;

  state_e state;

  logic signed [DATA_W-1:0] nva [MAX_NNZ];
  logic signed [DATA_W-1:0] nvb [MAX_NNZ];
  logic signed [DATA_W-1:0] nvc [MAX_NNZ];
  logic [IDX_W-1:0] cia [MAX_NNZ];
  logic [IDX_W-1:0] cib [MAX_NNZ];
  logic [IDX_W-1:0] cic [MAX_NNZ];
  logic [IDX_W-1:0] rpa [MAX_ROWS+1];
  logic [IDX_W-1:0] rpb [MAX_ROWS+1];
  logic [IDX_W-1:0] rpc [MAX_ROWS+1];

  logic [IDX_W-1:0] rows_a, rows_b, r;
  logic [PW-1:0] nnz_c, a_ptr, a_end;
  logic [PW-1:0] b_ptr, b_end, s, row_start;
  logic signed [DATA_W-1:0] scalar;
  logic busy, done, ovf, idx_err;

  function automatic logic signed [DATA_W-1:0] mul_f(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
`ifdef SPGEMM_SAT_EN
    logic signed [2*DATA_W-1:0] p;
    p = $signed({{DATA_W{a[DATA_W-1]}}, a})
      * $signed({{DATA_W{b[DATA_W-1]}}, b});
    if (p > D_MAX) return D_MAX;
    else if (p < D_MIN) return D_MIN;
    else return p[DATA_W-1:0];
`else
    return a * b;
`endif
  endfunction

  function automatic logic signed [DATA_W-1:0] add_f(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
`ifdef SPGEMM_SAT_EN
    logic signed [DATA_W:0] t;
    t = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (t > D_MAX) return D_MAX;
    else if (t < D_MIN) return D_MIN;
    else return t[DATA_W-1:0];
`else
    return a + b;
`endif
  endfunction

  logic [IDX_W-1:0] k, b_col, c_col;
  logic signed [DATA_W-1:0] prod, acc;
  logic put, full;

  assign k     = cia[AW'(a_ptr)];
  assign b_col = cib[AW'(b_ptr)];
  assign c_col = cic[AW'(s)];
  assign prod  = mul_f(scalar, nvb[AW'(b_ptr)]);
  assign acc   = add_f(nvc[AW'(s)], prod);
  assign put   = (s == nnz_c) || (c_col > b_col);
  assign full  = (nnz_c == PW'(MAX_NNZ));

  // Control FSM plus operand capture and result buffer updates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      rows_a    <= '0;
      rows_b    <= '0;
      r         <= '0;
      nnz_c     <= '0;
      a_ptr     <= '0;
      a_end     <= '0;
      b_ptr     <= '0;
      b_end     <= '0;
      s         <= '0;
      row_start <= '0;
      scalar    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      idx_err   <= 1'b0;
      for (int i = 0; i < MAX_NNZ; i++) begin
        nva[i] <= '0;
        nvb[i] <= '0;
        nvc[i] <= '0;
        cia[i] <= '0;
        cib[i] <= '0;
        cic[i] <= '0;
      end
      for (int i = 0; i <= MAX_ROWS; i++) begin
        rpa[i] <= '0;
        rpb[i] <= '0;
        rpc[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            rows_a  <= bus.rows_a_i;
            rows_b  <= bus.rows_b_i;
            r       <= '0;
            nnz_c   <= '0;
            ovf     <= 1'b0;
            idx_err <= 1'b0;
            busy    <= 1'b1;
            for (int i = 0; i < MAX_NNZ; i++) begin
              nva[i] <= bus.nva_i[i*DATA_W +: DATA_W];
              nvb[i] <= bus.nvb_i[i*DATA_W +: DATA_W];
              cia[i] <= bus.cia_i[i*IDX_W +: IDX_W];
              cib[i] <= bus.cib_i[i*IDX_W +: IDX_W];
              nvc[i] <= '0;
              cic[i] <= '0;
            end
            for (int i = 0; i <= MAX_ROWS; i++) begin
              rpa[i] <= bus.rpa_i[i*IDX_W +: IDX_W];
              rpb[i] <= bus.rpb_i[i*IDX_W +: IDX_W];
              rpc[i] <= '0;
            end
            state <= ROW_A;
          end
        end
        ROW_A: begin
          if (r == rows_a) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            a_ptr     <= PW'(rpa[RW'(r)]);
            a_end     <= PW'(rpa[RW'(r) + RW'(1)]);
            row_start <= nnz_c;
            state     <= ELEM_A;
          end
        end
        ELEM_A: begin
          if (a_ptr == a_end) begin
            state <= ROW_END;
          end else if (k >= rows_b) begin
            idx_err <= 1'b1;
            a_ptr   <= a_ptr + PW'(1);
          end else begin
            b_ptr  <= PW'(rpb[RW'(k)]);
            b_end  <= PW'(rpb[RW'(k) + RW'(1)]);
            s      <= row_start;
            scalar <= nva[AW'(a_ptr)];
            state  <= MERGE;
          end
        end
        MERGE: begin
          if (b_ptr == b_end) begin
            a_ptr <= a_ptr + PW'(1);
            state <= ELEM_A;
          end else if (put && full) begin
            ovf   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (put) begin
            for (int i = 1; i < MAX_NNZ; i++) begin
              if (PW'(i) > s && PW'(i) <= nnz_c) begin
                nvc[i] <= nvc[i-1];
                cic[i] <= cic[i-1];
              end
            end
            nvc[AW'(s)] <= prod;
            cic[AW'(s)] <= b_col;
            nnz_c <= nnz_c + PW'(1);
            b_ptr <= b_ptr + PW'(1);
            s     <= s + PW'(1);
          end else if (c_col < b_col) begin
            s <= s + PW'(1);
          end else begin
            nvc[AW'(s)] <= acc;
            b_ptr <= b_ptr + PW'(1);
            s     <= s + PW'(1);
          end
        end
        ROW_END: begin
          rpc[RW'(r) + RW'(1)] <= IDX_W'(nnz_c);
          r     <= r + IDX_W'(1);
          state <= ROW_A;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < MAX_NNZ; g++) begin : g_c
    assign bus.nvc_o[g*DATA_W +: DATA_W] = nvc[g];
    assign bus.cic_o[g*IDX_W +: IDX_W]   = cic[g];
  end

  for (genvar g = 0; g <= MAX_ROWS; g++) begin : g_rp
    assign bus.rpc_o[g*IDX_W +: IDX_W] = rpc[g];
  end

  assign bus.nnz_c_o   = nnz_c;
  assign bus.busy_o    = busy;
  assign bus.done_o    = done;
  assign bus.ovf_o     = ovf;
  assign bus.idx_err_o = idx_err;
endmodule

// File: tb/tb_spgemm_csr_engine.sv
// tb_spgemm_csr_engine: directed scoreboard bench for spgemm_csr_engine.
// dut0 uses default params; dut1 uses DATA_W=8, IDX_W=5 for dense/ovf/sat.
module tb_spgemm_csr_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spgemm_csr_engine_if bus0 ();
  spgemm_csr_engine_if #(.DATA_W(8), .IDX_W(5)) bus1 ();

  spgemm_csr_engine u_dut0 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus0)
  );

  spgemm_csr_engine #(.DATA_W(8), .IDX_W(5)) u_dut1 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus1)
  );

  typedef struct {
    int nnz;
    int ovf;
    int ierr;
    int rows;
    int nv[16];
    int ci[16];
    int rp[16];
  } res_t;

  res_t exp_q[$];
  int passed = 0;
  int total = 0;

  task automatic chk(input string tag, input longint obs, input longint exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
  endtask

  function automatic res_t blank();
    res_t e;
    e.nnz = 0; e.ovf = 0; e.ierr = 0; e.rows = 0;
    for (int i = 0; i < 16; i++) begin
      e.nv[i] = 0; e.ci[i] = 0; e.rp[i] = 0;
    end
    return e;
  endfunction

  task automatic clr0();
    bus0.rows_a_i = '0; bus0.rows_b_i = '0;
    bus0.nva_i = '0; bus0.nvb_i = '0;
    bus0.cia_i = '0; bus0.cib_i = '0;
    bus0.rpa_i = '0; bus0.rpb_i = '0;
  endtask

  task automatic clr1();
    bus1.rows_a_i = '0; bus1.rows_b_i = '0;
    bus1.nva_i = '0; bus1.nvb_i = '0;
    bus1.cia_i = '0; bus1.cib_i = '0;
    bus1.rpa_i = '0; bus1.rpb_i = '0;
  endtask

  task automatic a0(input int k, input int v, input int c);
    bus0.nva_i[k*32 +: 32] = v; bus0.cia_i[k*4 +: 4] = 4'(c);
  endtask
  task automatic b0(input int k, input int v, input int c);
    bus0.nvb_i[k*32 +: 32] = v; bus0.cib_i[k*4 +: 4] = 4'(c);
  endtask
  task automatic ra0(input int i, input int v);
    bus0.rpa_i[i*4 +: 4] = 4'(v);
  endtask
  task automatic rb0(input int i, input int v);
    bus0.rpb_i[i*4 +: 4] = 4'(v);
  endtask
  task automatic a1(input int k, input int v, input int c);
    bus1.nva_i[k*8 +: 8] = 8'(v); bus1.cia_i[k*5 +: 5] = 5'(c);
  endtask
  task automatic b1(input int k, input int v, input int c);
    bus1.nvb_i[k*8 +: 8] = 8'(v); bus1.cib_i[k*5 +: 5] = 5'(c);
  endtask
  task automatic ra1(input int i, input int v);
    bus1.rpa_i[i*5 +: 5] = 5'(v);
  endtask
  task automatic rb1(input int i, input int v);
    bus1.rpb_i[i*5 +: 5] = 5'(v);
  endtask

  task automatic compare(input string tag, input res_t g);
    res_t e;
    if (exp_q.size() == 0) begin
      chk({tag, ".queue"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".nnz"}, g.nnz, e.nnz);
    chk({tag, ".ovf"}, g.ovf, e.ovf);
    chk({tag, ".idx_err"}, g.ierr, e.ierr);
    for (int i = 0; i < e.nnz && i < 16; i++) begin
      chk($sformatf("%s.nv%0d", tag, i), g.nv[i], e.nv[i]);
      chk($sformatf("%s.ci%0d", tag, i), g.ci[i], e.ci[i]);
    end
    for (int i = 0; i <= e.rows; i++)
      chk($sformatf("%s.rp%0d", tag, i), g.rp[i], e.rp[i]);
  endtask

  task automatic go0(input string tag);
    res_t g;
    bit ok;
    ok = 1'b0;
    @(negedge clk); bus0.start_i = 1'b1;
    @(negedge clk); bus0.start_i = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (bus0.done_o) ok = 1'b1;
      else @(negedge clk);
    end
    chk({tag, ".done"}, ok, 1);
    g = blank();
    g.nnz = int'(bus0.nnz_c_o);
    g.ovf = int'(bus0.ovf_o);
    g.ierr = int'(bus0.idx_err_o);
    for (int i = 0; i < 16; i++) begin
      g.nv[i] = $signed(bus0.nvc_o[i*32 +: 32]);
      g.ci[i] = int'(bus0.cic_o[i*4 +: 4]);
      g.rp[i] = int'(bus0.rpc_o[i*4 +: 4]);
    end
    compare(tag, g);
  endtask

  task automatic go1(input string tag);
    res_t g;
    bit ok;
    ok = 1'b0;
    @(negedge clk); bus1.start_i = 1'b1;
    @(negedge clk); bus1.start_i = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (bus1.done_o) ok = 1'b1;
      else @(negedge clk);
    end
    chk({tag, ".done"}, ok, 1);
    g = blank();
    g.nnz = int'(bus1.nnz_c_o);
    g.ovf = int'(bus1.ovf_o);
    g.ierr = int'(bus1.idx_err_o);
    for (int i = 0; i < 16; i++) begin
      g.nv[i] = $signed(bus1.nvc_o[i*8 +: 8]);
      g.ci[i] = int'(bus1.cic_o[i*5 +: 5]);
      g.rp[i] = int'(bus1.rpc_o[i*5 +: 5]);
    end
    compare(tag, g);
  endtask

  task automatic load_ident0();
    clr0();
    bus0.rows_a_i = 4'd2; bus0.rows_b_i = 4'd2;
    a0(0, 1, 0); a0(1, 1, 1);
    b0(0, 1, 0); b0(1, 1, 1);
    ra0(0, 0); ra0(1, 1); ra0(2, 2);
    rb0(0, 0); rb0(1, 1); rb0(2, 2);
  endtask

  task automatic push_ident();
    res_t e;
    e = blank();
    e.nnz = 2; e.rows = 2;
    e.nv[0] = 1; e.nv[1] = 1;
    e.ci[0] = 0; e.ci[1] = 1;
    e.rp[0] = 0; e.rp[1] = 1; e.rp[2] = 2;
    exp_q.push_back(e);
  endtask

  initial begin
    res_t e;
    bus0.start_i = 1'b0; bus1.start_i = 1'b0;
    clr0(); clr1();

    repeat (2) @(negedge clk);
    chk("rst.nnz0", bus0.nnz_c_o, 0);
    chk("rst.busy0", bus0.busy_o, 0);
    chk("rst.done0", bus0.done_o, 0);
    chk("rst.flags0", {bus0.ovf_o, bus0.idx_err_o}, 0);
    chk("rst.nvc0", bus0.nvc_o == '0, 1);
    chk("rst.rpc1", bus1.rpc_o == '0, 1);
    rst_n = 1'b1;

    load_ident0();
    push_ident();
    go0("ident");

    clr0();
    bus0.rows_a_i = 4'd1; bus0.rows_b_i = 4'd2;
    a0(0, 2, 0); a0(1, 3, 1);
    ra0(0, 0); ra0(1, 2);
    b0(0, 4, 1); b0(1, 5, 0); b0(2, 6, 1);
    rb0(0, 0); rb0(1, 1); rb0(2, 3);
    e = blank();
    e.nnz = 2; e.rows = 1;
    e.nv[0] = 15; e.nv[1] = 26;
    e.ci[0] = 0; e.ci[1] = 1;
    e.rp[0] = 0; e.rp[1] = 2;
    exp_q.push_back(e);
    go0("insert");

    clr0();
    bus0.rows_a_i = 4'd1; bus0.rows_b_i = 4'd2;
    a0(0, 5, 7);
    ra0(0, 0); ra0(1, 1);
    b0(0, 1, 0); b0(1, 1, 1);
    rb0(0, 0); rb0(1, 1); rb0(2, 2);
    e = blank();
    e.ierr = 1; e.rows = 1;
    exp_q.push_back(e);
    go0("idxerr");

    bus0.rows_a_i = 4'd0;
    @(negedge clk); bus0.start_i = 1'b1;
    @(negedge clk); bus0.start_i = 1'b0;
    chk("rows0.busy1", bus0.busy_o, 1);
    chk("rows0.done1", bus0.done_o, 0);
    chk("rows0.flag_clr", bus0.idx_err_o, 0);
    @(negedge clk);
    chk("rows0.busy2", bus0.busy_o, 1);
    chk("rows0.done2", bus0.done_o, 1);
    @(negedge clk);
    chk("rows0.busy3", bus0.busy_o, 0);
    chk("rows0.done3", bus0.done_o, 0);
    chk("rows0.nnz", bus0.nnz_c_o, 0);

    clr0();
    bus0.rows_a_i = 4'd1; bus0.rows_b_i = 4'd2;
    a0(0, 2, 0); a0(1, 3, 1);
    ra0(0, 0); ra0(1, 2);
    b0(0, 4, 1); b0(1, 5, 0); b0(2, 6, 1);
    rb0(0, 0); rb0(1, 1); rb0(2, 3);
    @(negedge clk); bus0.start_i = 1'b1;
    @(negedge clk); bus0.start_i = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid.busy", bus0.busy_o, 1);
    chk("mid.nnz", bus0.nnz_c_o, 2);
    rst_n = 1'b0;
    #1;
    chk("arst.busy", bus0.busy_o, 0);
    chk("arst.nnz", bus0.nnz_c_o, 0);
    chk("arst.nvc", bus0.nvc_o == '0, 1);
    chk("arst.cic", bus0.cic_o == '0, 1);
    chk("arst.rpc", bus0.rpc_o == '0, 1);
    chk("arst.done", bus0.done_o, 0);
    @(negedge clk); rst_n = 1'b1;

    load_ident0();
    push_ident();
    go0("ident2");

    clr1();
    bus1.rows_a_i = 5'd4; bus1.rows_b_i = 5'd4;
    for (int i = 0; i < 16; i++) begin
      a1(i, 1, i % 4);
      b1(i, 1, i % 4);
    end
    for (int i = 0; i <= 4; i++) begin
      ra1(i, 4 * i);
      rb1(i, 4 * i);
    end
    e = blank();
    e.nnz = 16; e.rows = 4;
    for (int i = 0; i < 16; i++) begin
      e.nv[i] = 4; e.ci[i] = i % 4;
    end
    for (int i = 0; i <= 4; i++) e.rp[i] = 4 * i;
    exp_q.push_back(e);
    go1("dense");

    bus1.rows_a_i = 5'd5;
    bus1.nva_i = '0; bus1.cia_i = '0; bus1.rpa_i = '0;
    for (int i = 0; i < 5; i++) a1(i, 1, 0);
    for (int i = 0; i <= 5; i++) ra1(i, i);
    e = blank();
    e.nnz = 16; e.ovf = 1; e.rows = 5;
    for (int i = 0; i < 16; i++) begin
      e.nv[i] = 1; e.ci[i] = i % 4;
    end
    for (int i = 0; i <= 4; i++) e.rp[i] = 4 * i;
    e.rp[5] = 0;
    exp_q.push_back(e);
    go1("ovf");

    clr1();
    bus1.rows_a_i = 5'd1; bus1.rows_b_i = 5'd1;
    a1(0, 127, 0); ra1(0, 0); ra1(1, 1);
    b1(0, 2, 0); rb1(0, 0); rb1(1, 1);
    e = blank();
    e.nnz = 1; e.rows = 1;
`ifdef SPGEMM_SAT_EN
    e.nv[0] = 127;
`else
    e.nv[0] = -2;
`endif
    e.rp[1] = 1;
    exp_q.push_back(e);
    go1("sat");

    chk("queue.empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
